main_memory_ctrl: RTL and testbench

// Main-memory stage directly downstream of the L3 cache FSM. Accepts level-held read/write requests
// on the main_memory_* bus, models fixed access latency with a countdown, commits writes and

---
 rtl/main_memory_ctrl_pkg.sv | 30 +++
 rtl/main_memory_ctrl_array.sv | 27 ++
 rtl/main_memory_ctrl.sv | 145 ++++++++++++++
 tb/tb_main_memory_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/main_memory_ctrl_pkg.sv
// Shared configuration for the main-memory stage: bus widths, FSM and op encodings,
// default latencies and the address range check.
package main_memory_config;

    localparam int MAIN_MEMORY_DATA_WIDTH    = 16;
    localparam int MAIN_MEMORY_ADDRESS_WIDTH = 16;

    localparam int DEFAULT_MEM_DEPTH     = 1024;
    localparam int DEFAULT_READ_LATENCY  = 4;
    localparam int DEFAULT_WRITE_LATENCY = 6;
    localparam int DEFAULT_CNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        MM_IDLE    = 2'd0,
        MM_BUSY    = 2'd1,
        MM_RESPOND = 2'd2
    } mm_state_t;

    typedef enum logic {
        MM_OP_READ  = 1'b0,
        MM_OP_WRITE = 1'b1
    } mm_op_t;

    // Full-width compare so addresses just past the end never alias back into the array.
    function automatic logic mm_in_range(input logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] addr,
                                         input int unsigned depth);
        return (32'(addr) < depth);
    endfunction

endpackage

// File: rtl/main_memory_ctrl_array.sv
// Word storage for the main-memory stage: one synchronous write port, one
// combinational read port, zero at time 0 and untouched by reset.
module main_memory_array #(
    parameter int DEPTH = 1024,
    parameter int DW    = 16,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [IW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH] = '{default: '0};

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory stage behind the L3 FSM: latches a level-held request, counts down a
// fixed latency, then commits/returns and pulses ready for one cycle.
module main_memory_ctrl
    import main_memory_config::*;
#(
    parameter int MEM_DEPTH     = DEFAULT_MEM_DEPTH,
    parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
    parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] main_memory_address,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_write_data,
    input  logic                                 main_memory_read_request,
    input  logic                                 main_memory_write_request,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_read_data,
    output logic                                 main_memory_ready,
    output logic                                 main_memory_busy,
    output logic                                 main_memory_error,
    output logic [CNT_WIDTH-1:0]                 read_count,
    output logic [CNT_WIDTH-1:0]                 write_count
);

    localparam int IW      = $clog2(MEM_DEPTH);
    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    mm_state_t                             r_state;
    mm_op_t                                r_op;
    logic                                  r_dual;
    logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0]  r_addr;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0]     r_wdata;
    logic [LAT_W-1:0]                      r_count;
    logic                                  r_ready;
    logic                                  r_busy;
    logic                                  r_error;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0]     r_read_data;
    logic [CNT_WIDTH-1:0]                  r_read_count;
    logic [CNT_WIDTH-1:0]                  r_write_count;

    logic                                  w_in_range;
    logic                                  w_we;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0]     w_rdata;

    assign w_in_range = mm_in_range(r_addr, MEM_DEPTH);
    // The commit happens on the edge leaving RESPOND, so a reset during the access drops it.
    assign w_we       = (r_state == MM_RESPOND) && (r_op == MM_OP_WRITE) && w_in_range;

    main_memory_array #(
        .DEPTH (MEM_DEPTH),
        .DW    (MAIN_MEMORY_DATA_WIDTH),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr[IW-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (r_addr[IW-1:0]),
        .o_rdata (w_rdata)
    );

    // Access FSM with request latch, latency countdown, response flags and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= MM_IDLE;
            r_op          <= MM_OP_READ;
            r_dual        <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_count       <= '0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
            r_read_data   <= '0;
            r_read_count  <= '0;
            r_write_count <= '0;
        end else begin
            case (r_state)
                MM_IDLE: begin
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    if (main_memory_read_request || main_memory_write_request) begin
                        r_addr  <= main_memory_address;
                        r_wdata <= main_memory_write_data;
                        r_dual  <= main_memory_read_request && main_memory_write_request;
                        r_busy  <= 1'b1;
                        r_state <= MM_BUSY;
                        if (main_memory_write_request) begin
                            r_op    <= MM_OP_WRITE;
                            r_count <= LAT_W'(WRITE_LATENCY - 1);
                        end else begin
                            r_op    <= MM_OP_READ;
                            r_count <= LAT_W'(READ_LATENCY - 1);
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                MM_BUSY: begin
                    if (r_count == LAT_W'(0)) begin
                        r_state <= MM_RESPOND;
                        r_ready <= 1'b1;
                        r_error <= !w_in_range || r_dual;
                        if (r_op == MM_OP_READ) begin
                            r_read_data <= w_in_range ? w_rdata : '0;
                        end
                    end else begin
                        r_count <= r_count - LAT_W'(1);
                    end
                end
                MM_RESPOND: begin
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= MM_IDLE;
                    if (r_op == MM_OP_WRITE) begin
                        if (r_write_count != CNT_MAX) begin
                            r_write_count <= r_write_count + CNT_WIDTH'(1);
                        end
                    end else begin
                        if (r_read_count != CNT_MAX) begin
                            r_read_count <= r_read_count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state <= MM_IDLE;
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign main_memory_read_data = r_read_data;
    assign main_memory_ready     = r_ready;
    assign main_memory_busy      = r_busy;
    assign main_memory_error     = r_error;
    assign read_count            = r_read_count;
    assign write_count           = r_write_count;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed L3-style accesses followed by
// randomized ones, checked against a word-array reference model.
module tb_main_memory_ctrl;
    import main_memory_config::*;

    localparam int DEPTH = 1024;
    localparam int RL    = 4;
    localparam int WL    = 6;
    localparam int CW    = 4;
    localparam int AW    = MAIN_MEMORY_ADDRESS_WIDTH;
    localparam int DW    = MAIN_MEMORY_DATA_WIDTH;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] rdata;
    logic          ready, busy, error;
    logic [CW-1:0] rcnt, wcnt;

    main_memory_ctrl #(
        .MEM_DEPTH     (DEPTH),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .main_memory_address       (addr),
        .main_memory_write_data    (wdata),
        .main_memory_read_request  (rd),
        .main_memory_write_request (wr),
        .main_memory_read_data     (rdata),
        .main_memory_ready         (ready),
        .main_memory_busy          (busy),
        .main_memory_error         (error),
        .read_count                (rcnt),
        .write_count               (wcnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain word array, last returned read value, saturating counts.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rdata;
    int            m_rc;
    int            m_wc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One L3-style access: hold the request until ready, drop it one cycle later.
    task automatic do_op(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit scramble);
        int lat;
        int cyc;
        bit got;
        bit exp_err;
        lat     = w ? WL : RL;
        exp_err = (int'(a) >= DEPTH) || (r && w);
        rd = r; wr = w; addr = a; wdata = d;
        cyc = 0;
        got = 1'b0;
        while (cyc < 20 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (ready) begin
                got = 1'b1;
            end else begin
                chk("busy_in_flight", busy, 1);
                if (scramble) begin
                    addr  = AW'($urandom);
                    wdata = DW'($urandom);
                end
            end
        end
        chk("latency", cyc, lat + 1);
        if (w && int'(a) < DEPTH) m_mem[a] = d;
        if (!w) m_rdata = (int'(a) < DEPTH) ? m_mem[a] : '0;
        if (w) m_wc = (m_wc < CMAX) ? m_wc + 1 : CMAX;
        else   m_rc = (m_rc < CMAX) ? m_rc + 1 : CMAX;
        chk("error_with_ready", error, exp_err);
        chk("busy_with_ready", busy, 1);
        chk("read_data_with_ready", rdata, m_rdata);
        @(posedge clk); #1;
        chk("ready_one_cycle", ready, 0);
        chk("error_one_cycle", error, 0);
        chk("busy_after", busy, 0);
        chk("read_data_held", rdata, m_rdata);
        chk("read_count", rcnt, m_rc);
        chk("write_count", wcnt, m_wc);
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic          rr, ww;
        int            sel;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_rdata = '0; m_rc = 0; m_wc = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_error", error, 0);
        chk("reset_read_data", rdata, 0);
        chk("reset_read_count", rcnt, 0);
        chk("reset_write_count", wcnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 1'b1, 16'h0010, 16'hA5A5, 1'b0);
        do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        do_op(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b1);
        do_op(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1);
        do_op(1'b1, 1'b0, 16'(DEPTH + 3), 16'h0000, 1'b0);
        do_op(1'b0, 1'b1, 16'(DEPTH + 3), 16'h5A5A, 1'b0);
        do_op(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
        do_op(1'b1, 1'b1, 16'h0030, 16'hBEEF, 1'b0);
        do_op(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
        do_op(1'b0, 1'b1, 16'(DEPTH - 1), 16'h7E57, 1'b0);
        do_op(1'b1, 1'b0, 16'(DEPTH - 1), 16'h0000, 1'b0);
        do_op(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);

        for (int i = 0; i < 64; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0:       ra = 16'(DEPTH - 1);
                1:       ra = 16'(DEPTH);
                2:       ra = 16'hFFFF;
                3:       ra = 16'(DEPTH + $urandom_range(0, 15));
                default: ra = 16'(16'h0100 + $urandom_range(0, 15));
            endcase
            ww = (i % 2) == 1;
            rr = !ww || ((i % 7) == 0);
            do_op(rr, ww, ra, DW'($urandom), 1'b1);
        end
        chk("read_count_saturated", rcnt, CMAX);
        chk("write_count_saturated", wcnt, CMAX);

        rd = 1'b0; wr = 1'b1; addr = 16'h0040; wdata = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_reset", busy, 1);
        wr = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midreset_ready", ready, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_read_data", rdata, 0);
        chk("midreset_read_count", rcnt, 0);
        chk("midreset_write_count", wcnt, 0);
        m_rc = 0; m_wc = 0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_ready_in_reset", ready, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_op(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
